// File: rtl/router_reg_if.sv
// Bundles the FSM strobes, source byte stream, FIFO status and write-port
// outputs between the router control path and the router_reg datapath stage.
interface router_reg_if #(
   parameter int WIDTH = 8
);
   logic             pkt_valid;
   logic [WIDTH-1:0] data_in;
   logic             fifo_full;
   logic             detect_add;
   logic             lfd_state;
   logic             ld_state;
   logic             laf_state;
   logic             full_state;
   logic             rst_int_reg;
   logic [WIDTH-1:0] dout;
   logic             parity_done;
   logic             low_pkt_valid;
   logic             err;

   modport master (
      output pkt_valid, data_in, fifo_full,
      output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      input  dout, parity_done, low_pkt_valid, err
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      output dout, parity_done, low_pkt_valid, err
   );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, FIFO-full byte holding,
// running parity and end-of-packet parity check, all driven by FSM strobes.
module router_reg #(
   parameter int WIDTH = 8
) (
   input logic       clock,
   input logic       reset,
   router_reg_if.slave bus
);
   logic [WIDTH-1:0] r_hdr;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] r_int_par;
   logic [WIDTH-1:0] r_pkt_par;
   logic [WIDTH-1:0] r_dout;
   logic             r_parity_done;
   logic             r_low_pkt_valid;
   logic             r_err;
   logic             w_hdr_ok;
   logic             w_fold_data;

   function automatic logic [WIDTH-1:0] par_fold(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] b);
      return acc ^ b;
   endfunction

   // Address 3 is not a valid port, so its header never overwrites the last good one
   assign w_hdr_ok    = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
   assign w_fold_data = bus.ld_state && bus.pkt_valid && !bus.full_state;

   // Byte path: header, payload and the byte parked while the FIFO was full
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hdr     <= {WIDTH{1'b0}};
         r_hold    <= {WIDTH{1'b0}};
         r_dout    <= {WIDTH{1'b0}};
         r_int_par <= {WIDTH{1'b0}};
      end else begin
         if (w_hdr_ok) r_hdr <= bus.data_in;
         else          r_hdr <= r_hdr;

         if (bus.lfd_state)                      r_dout <= r_hdr;
         else if (bus.ld_state && !bus.fifo_full) r_dout <= bus.data_in;
         else if (bus.laf_state)                 r_dout <= r_hold;
         else                                    r_dout <= r_dout;

         if (bus.ld_state && bus.fifo_full) r_hold <= bus.data_in;
         else                               r_hold <= r_hold;

         if (bus.detect_add)     r_int_par <= {WIDTH{1'b0}};
         else if (bus.lfd_state) r_int_par <= par_fold(r_int_par, r_hdr);
         else if (w_fold_data)   r_int_par <= par_fold(r_int_par, bus.data_in);
         else                    r_int_par <= r_int_par;
      end
   end

   // Packet-end flags: parity byte capture, low_pkt_valid and the parity error verdict
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pkt_par       <= {WIDTH{1'b0}};
         r_parity_done   <= 1'b0;
         r_low_pkt_valid <= 1'b0;
         r_err           <= 1'b0;
      end else begin
         if (bus.ld_state && !bus.pkt_valid) r_low_pkt_valid <= 1'b1;
         else if (bus.rst_int_reg)           r_low_pkt_valid <= 1'b0;
         else                                r_low_pkt_valid <= r_low_pkt_valid;

         if (bus.detect_add) begin
            r_parity_done <= 1'b0;
            r_pkt_par     <= r_pkt_par;
         end else if (!r_parity_done && bus.ld_state && !bus.fifo_full && !bus.pkt_valid) begin
            r_parity_done <= 1'b1;
            r_pkt_par     <= bus.data_in;
         end else if (!r_parity_done && bus.laf_state && r_low_pkt_valid) begin
            r_parity_done <= 1'b1;
            r_pkt_par     <= r_hold;
         end else begin
            r_parity_done <= r_parity_done;
            r_pkt_par     <= r_pkt_par;
         end

         // The verdict stays visible until the next packet starts emitting data
         if (bus.rst_int_reg && r_parity_done) r_err <= (r_int_par != r_pkt_par);
         else if (bus.lfd_state)               r_err <= 1'b0;
         else                                  r_err <= r_err;
      end
   end

   assign bus.dout          = r_dout;
   assign bus.parity_done   = r_parity_done;
   assign bus.low_pkt_valid = r_low_pkt_valid;
   assign bus.err           = r_err;
endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed scenarios plus random packets,
// checked against a packet-level model (byte order, XOR parity, error carry-over).
module tb_router_reg;
   localparam int W = 8;
   localparam logic [5:0] S_IDLE = 6'b000000;
   localparam logic [5:0] S_DA   = 6'b100000;
   localparam logic [5:0] S_LFD  = 6'b010000;
   localparam logic [5:0] S_LD   = 6'b001000;
   localparam logic [5:0] S_LAF  = 6'b000100;
   localparam logic [5:0] S_FULL = 6'b000010;
   localparam logic [5:0] S_RST  = 6'b000001;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   router_reg_if #(.WIDTH(W)) bus ();
   router_reg #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

   int checks   = 0;
   int failures = 0;

   // Packet-level model state
   logic [7:0] model_hdr;
   bit         model_err;
   logic [7:0] last_dout;
   logic [7:0] pay_q[$];
   bit         full_q[$];

   task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
      {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state, bus.rst_int_reg} = st;
      bus.pkt_valid = pv;
      bus.data_in   = d;
      bus.fifo_full = ff;
      @(posedge clock);
      #1;
   endtask

   // Drives one packet (header, pay_q bytes, parity) as the FSM would and checks every step
   task automatic run_packet(input logic [7:0] hdr, input logic [7:0] par_mask, input bit full_par);
      logic [7:0] eff_hdr;
      logic [7:0] acc;
      logic [7:0] par;
      bit         exp_err;
      eff_hdr = (hdr[1:0] != 2'b11) ? hdr : model_hdr;
      acc = eff_hdr;
      foreach (pay_q[i]) acc = acc ^ pay_q[i];
      par     = acc ^ par_mask;
      exp_err = (par_mask != 8'h00);

      cyc(S_DA, 1'b1, hdr, 1'b0);
      checks++; if (bus.parity_done !== 1'b0) begin failures++; $display("FAIL da_parity_done got=%b exp=0", bus.parity_done); end
      checks++; if (bus.err !== model_err) begin failures++; $display("FAIL da_err_hold got=%b exp=%b", bus.err, model_err); end
      checks++; if (bus.dout !== last_dout) begin failures++; $display("FAIL da_dout_hold got=%h exp=%h", bus.dout, last_dout); end
      model_hdr = eff_hdr;

      cyc(S_LFD, 1'b1, 8'h00, 1'b0);
      checks++; if (bus.dout !== eff_hdr) begin failures++; $display("FAIL lfd_dout got=%h exp=%h", bus.dout, eff_hdr); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL lfd_err_clear got=%b exp=0", bus.err); end
      last_dout = eff_hdr;

      for (int i = 0; i < pay_q.size(); i++) begin
         if (full_q[i]) begin
            cyc(S_LD, 1'b1, pay_q[i], 1'b1);
            checks++; if (bus.dout !== last_dout) begin failures++; $display("FAIL full_ld_dout got=%h exp=%h", bus.dout, last_dout); end
            repeat (2) begin
               cyc(S_FULL, 1'b1, pay_q[i], 1'b1);
               checks++; if (bus.dout !== last_dout) begin failures++; $display("FAIL full_state_dout got=%h exp=%h", bus.dout, last_dout); end
            end
            cyc(S_LAF, 1'b1, pay_q[i], 1'b0);
            checks++; if (bus.dout !== pay_q[i]) begin failures++; $display("FAIL laf_dout got=%h exp=%h", bus.dout, pay_q[i]); end
            checks++; if (bus.parity_done !== 1'b0) begin failures++; $display("FAIL laf_parity_done got=%b exp=0", bus.parity_done); end
         end else begin
            cyc(S_LD, 1'b1, pay_q[i], 1'b0);
            checks++; if (bus.dout !== pay_q[i]) begin failures++; $display("FAIL ld_dout got=%h exp=%h", bus.dout, pay_q[i]); end
         end
         last_dout = pay_q[i];
      end

      if (full_par) begin
         cyc(S_LD, 1'b0, par, 1'b1);
         checks++; if (bus.low_pkt_valid !== 1'b1) begin failures++; $display("FAIL fullpar_lpv got=%b exp=1", bus.low_pkt_valid); end
         checks++; if (bus.parity_done !== 1'b0) begin failures++; $display("FAIL fullpar_pd_early got=%b exp=0", bus.parity_done); end
         checks++; if (bus.dout !== last_dout) begin failures++; $display("FAIL fullpar_dout_hold got=%h exp=%h", bus.dout, last_dout); end
         repeat (2) begin
            cyc(S_FULL, 1'b0, par, 1'b1);
            checks++; if (bus.parity_done !== 1'b0) begin failures++; $display("FAIL fullpar_pd_full got=%b exp=0", bus.parity_done); end
         end
         cyc(S_LAF, 1'b0, par, 1'b0);
         checks++; if (bus.dout !== par) begin failures++; $display("FAIL fullpar_laf_dout got=%h exp=%h", bus.dout, par); end
         checks++; if (bus.parity_done !== 1'b1) begin failures++; $display("FAIL fullpar_pd_laf got=%b exp=1", bus.parity_done); end
      end else begin
         cyc(S_LD, 1'b0, par, 1'b0);
         checks++; if (bus.dout !== par) begin failures++; $display("FAIL par_dout got=%h exp=%h", bus.dout, par); end
         checks++; if (bus.parity_done !== 1'b1) begin failures++; $display("FAIL par_done got=%b exp=1", bus.parity_done); end
         checks++; if (bus.low_pkt_valid !== 1'b1) begin failures++; $display("FAIL par_lpv got=%b exp=1", bus.low_pkt_valid); end
      end
      last_dout = par;

      cyc(S_RST, 1'b0, 8'h00, 1'b0);
      checks++; if (bus.err !== exp_err) begin failures++; $display("FAIL chk_err got=%b exp=%b", bus.err, exp_err); end
      checks++; if (bus.low_pkt_valid !== 1'b0) begin failures++; $display("FAIL chk_lpv_clear got=%b exp=0", bus.low_pkt_valid); end

      cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
      checks++; if (bus.err !== exp_err) begin failures++; $display("FAIL idle_err_hold got=%b exp=%b", bus.err, exp_err); end
      checks++; if (bus.dout !== last_dout) begin failures++; $display("FAIL idle_dout_hold got=%h exp=%h", bus.dout, last_dout); end
      model_err = exp_err;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
      checks++; if ({bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err} !== 11'd0) begin failures++; $display("FAIL reset_init got=%h exp=0", {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err}); end
      reset = 1'b0;
      cyc(S_DA, 1'b1, 8'hA5, 1'b0);
      cyc(S_LFD, 1'b1, 8'h00, 1'b0);
      checks++; if (bus.dout !== 8'hA5) begin failures++; $display("FAIL pre_reset_dout got=%h exp=a5", bus.dout); end
      cyc(S_LD, 1'b0, 8'h5A, 1'b1);
      checks++; if (bus.low_pkt_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_lpv got=%b exp=1", bus.low_pkt_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL async_reset_dout got=%h exp=00", bus.dout); end
      checks++; if ({bus.parity_done, bus.low_pkt_valid, bus.err} !== 3'b000) begin failures++; $display("FAIL async_reset_flags got=%b exp=000", {bus.parity_done, bus.low_pkt_valid, bus.err}); end
      #1 reset = 1'b0;
      model_hdr = 8'h00;
      model_err = 1'b0;
      last_dout = 8'h00;
      // Header register must be cleared too: an address-3 packet re-emits it
      pay_q = '{8'h44}; full_q = '{1'b0};
      run_packet(8'hF3, 8'h00, 1'b0);
   endtask

   task automatic test_clean_packet();
      pay_q = '{8'h11, 8'h22, 8'h33}; full_q = '{1'b0, 1'b0, 1'b0};
      run_packet(8'h0D, 8'h00, 1'b0);
   endtask

   task automatic test_bad_parity();
      pay_q = '{8'h11, 8'h22, 8'h33}; full_q = '{1'b0, 1'b0, 1'b0};
      run_packet(8'h0D, 8'h31, 1'b0);
      // The next packet keeps err visible through detect_add and clears it at lfd
      pay_q = '{8'h11, 8'h22, 8'h33}; full_q = '{1'b0, 1'b0, 1'b0};
      run_packet(8'h0D, 8'h00, 1'b0);
   endtask

   task automatic test_full_payload();
      pay_q = '{8'h11, 8'h22, 8'h33}; full_q = '{1'b0, 1'b1, 1'b0};
      run_packet(8'h0D, 8'h00, 1'b0);
   endtask

   task automatic test_full_parity();
      pay_q = '{8'h11, 8'h22, 8'h33}; full_q = '{1'b0, 1'b0, 1'b0};
      run_packet(8'h0D, 8'h00, 1'b1);
      pay_q = '{8'h5C, 8'h81}; full_q = '{1'b1, 1'b0};
      run_packet(8'h62, 8'h04, 1'b1);
   endtask

   task automatic test_addr3();
      pay_q = '{8'h99}; full_q = '{1'b0};
      run_packet(8'h0D, 8'h00, 1'b0);
      pay_q = '{8'h11, 8'h22}; full_q = '{1'b0, 1'b0};
      run_packet(8'h07, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      for (int p = 0; p < 40; p++) begin
         int unsigned len;
         logic [7:0]  hdr;
         logic [7:0]  mask;
         len = $urandom_range(1, 6);
         pay_q.delete();
         full_q.delete();
         for (int i = 0; i < int'(len); i++) begin
            pay_q.push_back(8'($urandom));
            full_q.push_back($urandom_range(0, 3) == 0);
         end
         hdr  = 8'($urandom);
         mask = ($urandom_range(0, 2) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
         run_packet(hdr, mask, ($urandom_range(0, 2) == 0));
      end
   endtask

   initial begin
      bus.pkt_valid = 1'b0; bus.data_in = 8'h00; bus.fifo_full = 1'b0;
      bus.detect_add = 1'b0; bus.lfd_state = 1'b0; bus.ld_state = 1'b0;
      bus.laf_state = 1'b0; bus.full_state = 1'b0; bus.rst_int_reg = 1'b0;
      reset = 1'b1;
      #12;
      test_reset();
      test_clean_packet();
      test_bad_parity();
      test_full_payload();
      test_full_parity();
      test_addr3();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
